// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter measuring the frequency of an async input in Hz
// Counts synchronized rising edges of sigIn over a 1/GATE_DIV second window and publishes n*GATE_DIV.
module freq_meter #(
  parameter int BASE_SPEED = 50000000,
  parameter int GATE_DIV   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sigIn,
  output logic [19:0] freq,
  output logic        freqValid,
  output logic        overflow,
  output logic        sigPresent
);

  localparam int G  = BASE_SPEED / GATE_DIV;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  // 21 bits: once saturated, n*GATE_DIV is always above the 20-bit limit, so overflow stays correct.
  localparam int EW = 21;
  localparam int DW = (GATE_DIV > 1) ? $clog2(GATE_DIV) : 1;
  localparam int PW = EW + DW + 1;

  localparam logic [GW-1:0] G_LAST = GW'(G - 1);
  localparam logic [PW-1:0] F_MAX  = PW'(20'hFFFFF);
  localparam logic [PW-1:0] SCALE  = PW'(GATE_DIV);

  generate
    if (BASE_SPEED % GATE_DIV != 0) begin : g_bad_gate_div
      $error("freq_meter: BASE_SPEED must be a multiple of GATE_DIV");
    end
  endgenerate

  logic          s1, s2, prev;
  logic [1:0]    warm;
  logic [GW-1:0] gate;
  logic [EW-1:0] edges;
  logic          rise;
  logic          terminal;
  logic [EW-1:0] n;
  logic [PW-1:0] prod;

  // Warm-up masks the first three cycles so an input held high through reset is not seen as an edge.
  assign rise     = s2 & ~prev & (warm == 2'd3);
  assign terminal = (gate == G_LAST);

  always_comb begin
    n = edges;
    if (rise && (edges != '1)) begin
      n = edges + 1'b1;
    end
    prod = PW'(n) * SCALE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      prev       <= 1'b0;
      warm       <= 2'd0;
      gate       <= '0;
      edges      <= '0;
      freq       <= 20'd0;
      freqValid  <= 1'b0;
      overflow   <= 1'b0;
      sigPresent <= 1'b0;
    end else begin
      s1        <= sigIn;
      s2        <= s1;
      prev      <= s2;
      freqValid <= 1'b0;
      if (warm != 2'd3) begin
        warm <= warm + 2'd1;
      end
      if (terminal) begin
        // An edge landing in the terminal cycle is folded into the closing window through n.
        gate       <= '0;
        edges      <= '0;
        freqValid  <= 1'b1;
        freq       <= (prod > F_MAX) ? 20'hFFFFF : prod[19:0];
        overflow   <= (prod > F_MAX);
        sigPresent <= (n != '0);
      end else begin
        gate <= gate + 1'b1;
        if (rise && (edges != '1)) begin
          edges <= edges + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
// Four parameterisations share one clock; only the selected instance is out of reset.
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   sel = 0;
  logic rst = 1'b1;
  logic sig = 1'b0;

  logic [19:0] f_a, f_b, f_c, f_d;
  logic        v_a, v_b, v_c, v_d;
  logic        o_a, o_b, o_c, o_d;
  logic        p_a, p_b, p_c, p_d;

  freq_meter #(.BASE_SPEED(1000), .GATE_DIV(1)) u_a (
    .clk(clk), .reset(rst | (sel != 0)), .sigIn((sel == 0) ? sig : 1'b0),
    .freq(f_a), .freqValid(v_a), .overflow(o_a), .sigPresent(p_a));
  freq_meter #(.BASE_SPEED(1000), .GATE_DIV(4)) u_b (
    .clk(clk), .reset(rst | (sel != 1)), .sigIn((sel == 1) ? sig : 1'b0),
    .freq(f_b), .freqValid(v_b), .overflow(o_b), .sigPresent(p_b));
  freq_meter #(.BASE_SPEED(2097152), .GATE_DIV(1024)) u_c (
    .clk(clk), .reset(rst | (sel != 2)), .sigIn((sel == 2) ? sig : 1'b0),
    .freq(f_c), .freqValid(v_c), .overflow(o_c), .sigPresent(p_c));
  freq_meter #(.BASE_SPEED(4194304), .GATE_DIV(1024)) u_d (
    .clk(clk), .reset(rst | (sel != 3)), .sigIn((sel == 3) ? sig : 1'b0),
    .freq(f_d), .freqValid(v_d), .overflow(o_d), .sigPresent(p_d));

  logic [19:0] m_f;
  logic        m_v, m_o, m_p;

  always_comb begin
    m_f = 20'd0; m_v = 1'b0; m_o = 1'b0; m_p = 1'b0;
    case (sel)
      0: begin m_f = f_a; m_v = v_a; m_o = o_a; m_p = p_a; end
      1: begin m_f = f_b; m_v = v_b; m_o = o_b; m_p = p_b; end
      2: begin m_f = f_c; m_v = v_c; m_o = o_c; m_p = p_c; end
      3: begin m_f = f_d; m_v = v_d; m_o = o_d; m_p = p_d; end
      default: ;
    endcase
  end

  int n_chk  = 0;
  int n_fail = 0;
  int rc     = 0;
  int mode   = 0;
  int per    = 10;
  int hi     = 5;
  int pl[$];
  int pc[$];
  int pf[$];
  int po[$];
  int pp[$];

  function automatic logic gen(int c);
    if (mode == 0) return ((c % per) < hi);
    foreach (pl[i]) if (c >= pl[i] && c < pl[i] + 3) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rc++;
    sig = gen(rc);
    if (m_v) begin
      pc.push_back(rc);
      pf.push_back(int'(m_f));
      po.push_back(int'(m_o));
      pp.push_back(int'(m_p));
    end
  endtask

  task automatic run(int cycles);
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic start(int s);
    sel = s;
    rst = 1'b1;
    rc  = 0;
    sig = gen(0);
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_freq", int'(m_f), 0);
    chk("rst_valid", int'(m_v), 0);
    chk("rst_ovf", int'(m_o), 0);
    chk("rst_present", int'(m_p), 0);
    rst = 1'b0;
    pc.delete(); pf.delete(); po.delete(); pp.delete();
  endtask

  int bad;

  initial begin
    // 10-cycle square wave on G=1000: pulses at 1000/2000/3000, 100 Hz in full windows
    mode = 0; per = 10; hi = 5;
    start(0);
    run(3001);
    chk("a_npulses", pc.size(), 3);
    chk("a_pulse0_cycle", pc[0], 1000);
    chk("a_pulse1_cycle", pc[1], 2000);
    chk("a_pulse2_cycle", pc[2], 3000);
    chk("a_freq1", pf[1], 100);
    chk("a_freq2", pf[2], 100);
    chk("a_present1", pp[1], 1);
    chk("a_ovf1", po[1], 0);

    // input held high through and after reset must never register an edge
    mode = 0; per = 10; hi = 10;
    start(0);
    run(2001);
    chk("h_npulses", pc.size(), 2);
    chk("h_freq0", pf[0], 0);
    chk("h_present0", pp[0], 0);
    chk("h_freq1", pf[1], 0);
    chk("h_present1", pp[1], 0);

    // rising edge reaching s2 in the terminal cycle belongs to the closing window
    mode = 1; pl = '{100, 200, 300, 997, 1100, 1200};
    start(0);
    run(2001);
    chk("t_npulses", pc.size(), 2);
    chk("t_win0", pf[0], 4);
    chk("t_win1", pf[1], 2);
    chk("t_total", pf[0] + pf[1], 6);

    // reset mid-window aborts it; next pulse one full window after release
    mode = 0; per = 10; hi = 5;
    start(0);
    run(1500);
    chk("r_npulses_before", pc.size(), 1);
    chk("r_pulse0_cycle", pc[0], 1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 0;
    if (m_v || m_f != 20'd0 || m_o || m_p) bad++;
    for (int k = 1; k < 1000; k++) begin
      tick();
      if (m_v || m_f != 20'd0 || m_o || m_p) bad++;
    end
    chk("r_quiet_cycles", bad, 0);
    tick();
    chk("r_cycle_now", rc, 2501);
    chk("r_valid_2501", int'(m_v), 1);
    chk("r_present_2501", int'(m_p), 1);

    // G=250, GATE_DIV=4, period 4: 62/63 edges per window, scaled to 248/252
    mode = 0; per = 4; hi = 2;
    start(1);
    run(751);
    chk("b4_npulses", pc.size(), 3);
    chk("b4_pulse0_cycle", pc[0], 250);
    n_chk++;
    assert (pf[1] == 248 || pf[1] == 252) else begin
      n_fail++;
      $error("FAIL b4_freq1: observed %0d expected 248 or 252", pf[1]);
    end
    n_chk++;
    assert (pf[2] == 248 || pf[2] == 252) else begin
      n_fail++;
      $error("FAIL b4_freq2: observed %0d expected 248 or 252", pf[2]);
    end

    // period 5 divides the window exactly: 50 edges * 4 = 200
    mode = 0; per = 5; hi = 3;
    start(1);
    run(751);
    chk("b5_freq1", pf[1], 200);
    chk("b5_freq2", pf[2], 200);

    // 512 edges * 1024 = 524288 still fits in 20 bits
    mode = 0; per = 4; hi = 2;
    start(2);
    run(4097);
    chk("c_npulses", pc.size(), 2);
    chk("c_freq1", pf[1], 524288);
    chk("c_ovf1", po[1], 0);
    chk("c_present1", pp[1], 1);

    // 1024 edges * 1024 = 1048576 saturates to 20'hFFFFF
    start(3);
    run(8193);
    chk("d_npulses", pc.size(), 2);
    chk("d_freq1", pf[1], 20'hFFFFF);
    chk("d_ovf1", po[1], 1);
    chk("d_present1", pp[1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
